// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in serial-out serializer.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  // Counter must be able to index every data bit of the word.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load-side and serial-side handshake bundle for piso_serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);

  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             ser_ready;
  logic             ser_out;
  logic             ser_valid;

  modport master (
    output load_valid,
    output load_data,
    output ser_ready,
    input  load_ready,
    input  ser_out,
    input  ser_valid
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  ser_ready,
    output load_ready,
    output ser_out,
    output ser_valid
  );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage with zero-gap back-to-back words and downstream stall.
// Define PISO_PARITY_EN to append an even-parity bit after each word.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  piso_serializer_if.slave   bus,
  output logic               busy,
  output logic               frame_done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic             ser_out_q;
  logic             ser_valid_q;

  logic beat;
  logic last_data;
  logic last_beat;
  logic accept;

  assign beat      = ser_valid_q && bus.ser_ready;
  assign last_data = (state == SHIFT) && beat && (bit_cnt == LAST_CNT);

`ifdef PISO_PARITY_EN
  logic parity_q;
  assign last_beat = (state == PARITY) && beat;
`else
  assign last_beat = last_data;
`endif

  // A new word may enter in the same cycle the previous frame's final bit leaves.
  assign bus.load_ready = (state == IDLE) || last_beat;
  assign accept         = bus.load_valid && bus.load_ready;

  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      frame_done <= last_beat;
      if (accept) begin
        state       <= SHIFT;
        shreg       <= MSB_FIRST ? {bus.load_data[WIDTH-2:0], 1'b0}
                                 : {1'b0, bus.load_data[WIDTH-1:1]};
        ser_out_q   <= MSB_FIRST ? bus.load_data[WIDTH-1] : bus.load_data[0];
        bit_cnt     <= '0;
        ser_valid_q <= 1'b1;
        busy        <= 1'b1;
`ifdef PISO_PARITY_EN
        parity_q    <= ^bus.load_data;
`endif
      end else if (last_beat) begin
        state       <= IDLE;
        shreg       <= '0;
        bit_cnt     <= '0;
        ser_out_q   <= 1'b0;
        ser_valid_q <= 1'b0;
        busy        <= 1'b0;
`ifdef PISO_PARITY_EN
      end else if (last_data) begin
        state     <= PARITY;
        ser_out_q <= parity_q;
`endif
      end else if (beat) begin
        // shreg already has the emitted bit removed, so its leading bit is next.
        ser_out_q <= MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        shreg     <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                               : {1'b0, shreg[WIDTH-1:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out stage directly upstream of the 4-bit SIPO shift register.
- Accepts a WIDTH-bit word on a valid/ready handshake and emits it one bit per beat as ser_out/ser_valid. ser_valid drives the SIPO's shift_en and ser_out drives its data_in.
- Supports back-to-back words with no idle bit and downstream stall via ser_ready.

Parameters:
- WIDTH, 4, word width in bits; legal range is WIDTH >= 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  upstream word valid.
- load_data  input  WIDTH  word to serialize; sampled only on accept.
- load_ready  output  1  block can accept a word this cycle (combinational).
- ser_ready  input  1  downstream can take a bit this cycle.
- ser_out  output  1  current serial bit (registered).
- ser_valid  output  1  ser_out is valid (registered); drives SIPO shift_en.
- busy  output  1  a word is in flight (registered).
- frame_done  output  1  one-cycle pulse, registered, in the cycle after a word's final beat.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, shift register=0, bit_cnt=0.
  - ser_out=0, ser_valid=0, busy=0, frame_done=0.
  - load_ready=1 while in IDLE, including during reset.
- Definitions:
  - accept = load_valid && load_ready.
  - beat = ser_valid && ser_ready.
  - last beat = beat on the final bit of a frame. The final bit is the data bit with bit_cnt==WIDTH-1, or the parity bit when the optional feature is enabled.
- States: IDLE, SHIFT, plus PARITY when the optional feature is enabled.
- IDLE:
  - load_ready=1.
  - On accept: latch load_data, bit_cnt=0, go to SHIFT.
  - The next cycle has ser_valid=1, busy=1 and ser_out=first bit. Latency from accept to first bit is 1 cycle.
- SHIFT:
  - On beat: shift register advances by one bit and bit_cnt increments.
  - No beat (ser_ready=0): ser_out, ser_valid and bit_cnt all hold.
  - ser_valid never deasserts mid-frame.
- load_ready in SHIFT/PARITY equals (last beat this cycle), combinational from ser_ready.
- Last beat:
  - Always: frame_done=1 next cycle.
  - With accept: load the new word, stay in SHIFT, ser_valid stays 1, and the next cycle carries the new word's first bit (zero-gap streaming).
  - Without accept: go to IDLE; ser_valid=0, busy=0 and ser_out=0 next cycle.
- Simultaneous events:
  - load_valid while not load_ready: the word is ignored, and load_data is not sampled.
  - Asserting rst mid-frame aborts the frame immediately. No frame_done is produced; the partial word is discarded.
- bit_cnt width is $clog2(WIDTH+1) bits, with no wrap beyond WIDTH-1.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the final data beat, go to PARITY and emit one extra bit = XOR of the latched word (even parity).
  - Beat and stall rules are the same as SHIFT.
  - The parity beat is the last beat: frame_done and back-to-back loading attach to it.
  - A frame is WIDTH+1 beats.
- Undefined: PARITY state and parity logic are absent; a frame is WIDTH beats.

Decomposition:
- Shared package piso_pkg:
  - State typedef (IDLE, SHIFT, PARITY).
  - Localparam helper for the bit_cnt width.
- Single module; no sub-module is natural. Shift register, counter and FSM are tightly coupled.

Test Plan (WIDTH=4, ser_ready=1 unless noted):
- MSB_FIRST=1, load 4'b1011 once → ser_out 1,0,1,1 on 4 consecutive cycles starting 1 cycle after accept; frame_done pulses on the 5th cycle; a downstream SIPO shows data_out=1011; busy drops after the 4th bit.
- Back-to-back: 4'b1011 then 4'b0110, with the second accepted on the last beat → ser_out 1,0,1,1,0,1,1,0 on 8 consecutive cycles; ser_valid never low; frame_done pulses twice.
- Stall: ser_ready=0 for 3 cycles while the 2nd bit of 1011 is presented → ser_out holds 0 and ser_valid holds 1 for those 3 cycles; the frame completes 3 cycles late with bits intact.
- MSB_FIRST=0, load 4'b1011 → ser_out 1,1,0,1.
- Reset mid-frame: assert rst after 2 bits of 1011 → ser_valid=0 and ser_out=0 immediately; no frame_done; load_ready=1; a fresh 4'b0110 then serializes correctly.
- PISO_PARITY_EN defined, load 4'b1011 → ser_out 1,0,1,1,1 (parity=1); frame_done after the 5th beat; 4'b0110 gives parity bit 0.
